bcd_accumulator: RTL and testbench

BCD_ACCUMULATOR -- requirements
Module: bcd_accumulator

---
 rtl/bcd_accumulator.sv | 121 ++++++++++++
 tb/tb_bcd_accumulator.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_accumulator.sv
// Two-digit BCD accumulator: adds a BCD operand into Q one digit per cycle (IDLE->LO->HI->DONE).
// Define BCD_ACC_SAT_EN to saturate Q at 8'h99 on a hundreds carry instead of wrapping modulo 100.

module bcd_digit_add (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [4:0] raw;

  assign raw = {1'b0, a} + {1'b0, b} + {4'b0, cin};

  always_comb begin
    cout = (raw > 5'd9);
    sum  = cout ? 4'(raw - 5'd10) : raw[3:0];
  end
endmodule

module bcd_accumulator (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Clr,
  input  logic       Go,
  input  logic [7:0] DIN,
  output logic [7:0] Q,
  output logic       Busy,
  output logic       Done,
  output logic       Ovf,
  output logic       Err
);
  localparam int NUM_DIGITS = 2;

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t                         state;
  logic [7:0]                     op;
  logic                           c;
  logic [NUM_DIGITS-1:0][3:0]     dsum;
  logic [NUM_DIGITS-1:0]          dcout;
  logic                           din_ok;

  assign din_ok = (DIN[7:4] <= 4'd9) && (DIN[3:0] <= 4'd9);

  // Both digit adders run continuously; the FSM picks which result to commit.
  // The tens digit takes the carry latched during LO, not the live ones carry.
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    bcd_digit_add u_dig (
      .a    (Q[4*i +: 4]),
      .b    (op[4*i +: 4]),
      .cin  ((i == 0) ? 1'b0 : c),
      .sum  (dsum[i]),
      .cout (dcout[i])
    );
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      Q     <= 8'h00;
      op    <= 8'h00;
      c     <= 1'b0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
      Ovf   <= 1'b0;
      Err   <= 1'b0;
    end else if (Clr) begin
      state <= IDLE;
      Q     <= 8'h00;
      c     <= 1'b0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
      Ovf   <= 1'b0;
      Err   <= 1'b0;
    end else begin
      Done <= 1'b0;
      Err  <= 1'b0;
      case (state)
        IDLE: begin
          if (Go) begin
            if (din_ok) begin
              op    <= DIN;
              state <= LO;
              Busy  <= 1'b1;
            end else begin
              Err <= 1'b1;
            end
          end
        end
        LO: begin
          Q[3:0] <= dsum[0];
          c      <= dcout[0];
          state  <= HI;
        end
        HI: begin
          if (dcout[1]) begin
            Ovf <= 1'b1;
`ifdef BCD_ACC_SAT_EN
            Q <= 8'h99;
`else
            Q[7:4] <= dsum[1];
`endif
          end else begin
            Q[7:4] <= dsum[1];
          end
          state <= DONE;
          Done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_accumulator.sv
// Scoreboard bench for bcd_accumulator: stimulus pushes expected totals/Err events,
// a forked monitor pops and compares them whenever Done or Err is presented.

module tb_bcd_accumulator;
  logic       Clock = 1'b0;
  logic       Reset, Clr, Go;
  logic [7:0] DIN;
  logic [7:0] Q;
  logic       Busy, Done, Ovf, Err;

  int tests = 0;
  int fails = 0;

  logic [8:0] sb_q[$];   // {ovf, q} expected at each Done
  logic [7:0] err_q[$];  // Q expected to be held at each Err

  bcd_accumulator dut (
    .Clock (Clock),
    .Reset (Reset),
    .Clr   (Clr),
    .Go    (Go),
    .DIN   (DIN),
    .Q     (Q),
    .Busy  (Busy),
    .Done  (Done),
    .Ovf   (Ovf),
    .Err   (Err)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic monitor();
    logic [8:0] e;
    logic [7:0] eq;
    forever begin
      @(negedge Clock);
      if (Done === 1'b1) begin
        if (sb_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_done: got Done=1 Q=%0h expected no Done", Q);
        end else begin
          e = sb_q.pop_front();
          chk("done_q", {24'h0, Q}, {24'h0, e[7:0]});
          chk("done_ovf", {31'h0, Ovf}, {31'h0, e[8]});
        end
      end
      if (Err === 1'b1) begin
        if (err_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_err: got Err=1 expected no Err");
        end else begin
          eq = err_q.pop_front();
          chk("err_q_held", {24'h0, Q}, {24'h0, eq});
        end
      end
    end
  endtask

  task automatic run_add(input logic [7:0] din, input logic [7:0] eq, input logic eovf,
                         input logic [3:0] elo, input string nm);
    sb_q.push_back({eovf, eq});
    Go = 1'b1; DIN = din;
    tick();
    Go = 1'b0;
    chk({nm, "_busy_lo"}, {31'h0, Busy}, 32'h1);
    tick();
    chk({nm, "_ones_after_lo"}, {28'h0, Q[3:0]}, {28'h0, elo});
    chk({nm, "_busy_hi"}, {31'h0, Busy}, 32'h1);
    tick();
    chk({nm, "_done"}, {31'h0, Done}, 32'h1);
    chk({nm, "_busy_done"}, {31'h0, Busy}, 32'h1);
    chk({nm, "_tens_after_hi"}, {28'h0, Q[7:4]}, {28'h0, eq[7:4]});
    tick();
    chk({nm, "_busy_idle"}, {31'h0, Busy}, 32'h0);
    chk({nm, "_done_low"}, {31'h0, Done}, 32'h0);
  endtask

  task automatic bad_req(input logic [7:0] din, input logic [7:0] held, input string nm);
    err_q.push_back(held);
    Go = 1'b1; DIN = din;
    tick();
    Go = 1'b0;
    chk({nm, "_err"}, {31'h0, Err}, 32'h1);
    chk({nm, "_busy"}, {31'h0, Busy}, 32'h0);
    tick();
    chk({nm, "_err_pulse"}, {31'h0, Err}, 32'h0);
    chk({nm, "_busy2"}, {31'h0, Busy}, 32'h0);
    chk({nm, "_q"}, {24'h0, Q}, {24'h0, held});
    chk({nm, "_ovf"}, {31'h0, Ovf}, 32'h1);
  endtask

  initial begin
    int ndone;
    Reset = 1'b1; Clr = 1'b0; Go = 1'b0; DIN = 8'h00;
    fork
      monitor();
    join_none
    tick(); tick();
    Reset = 1'b0;
    chk("rst_q", {24'h0, Q}, 32'h0);
    chk("rst_busy", {31'h0, Busy}, 32'h0);
    chk("rst_done", {31'h0, Done}, 32'h0);
    chk("rst_ovf", {31'h0, Ovf}, 32'h0);
    chk("rst_err", {31'h0, Err}, 32'h0);

    run_add(8'h47, 8'h47, 1'b0, 4'h7, "add47");
    run_add(8'h38, 8'h85, 1'b0, 4'h5, "add38");
`ifdef BCD_ACC_SAT_EN
    run_add(8'h27, 8'h99, 1'b1, 4'h2, "add27");
    run_add(8'h01, 8'h99, 1'b1, 4'h0, "add01");
    bad_req(8'h3A, 8'h99, "bad3A");
    bad_req(8'hA3, 8'h99, "badA3");
`else
    run_add(8'h27, 8'h12, 1'b1, 4'h2, "add27");
    run_add(8'h01, 8'h13, 1'b1, 4'h3, "add01");
    bad_req(8'h3A, 8'h13, "bad3A");
    bad_req(8'hA3, 8'h13, "badA3");
`endif

    // Clr while in LO: abort, no Done expected
    Go = 1'b1; DIN = 8'h11;
    tick();
    Go = 1'b0;
    Clr = 1'b1;
    tick();
    Clr = 1'b0;
    chk("clr_lo_q", {24'h0, Q}, 32'h0);
    chk("clr_lo_ovf", {31'h0, Ovf}, 32'h0);
    chk("clr_lo_busy", {31'h0, Busy}, 32'h0);
    tick(); tick(); tick();
    chk("clr_lo_still_idle", {31'h0, Busy}, 32'h0);

    // Clr and Go together in IDLE: clear wins
    run_add(8'h22, 8'h22, 1'b0, 4'h2, "add22");
    Clr = 1'b1; Go = 1'b1; DIN = 8'h05;
    tick();
    Clr = 1'b0; Go = 1'b0;
    chk("clrgo_q", {24'h0, Q}, 32'h0);
    chk("clrgo_busy", {31'h0, Busy}, 32'h0);
    tick();
    chk("clrgo_busy2", {31'h0, Busy}, 32'h0);

    // Reset while in HI, with an addition that would have carried out
    run_add(8'h05, 8'h05, 1'b0, 4'h5, "add05");
    Go = 1'b1; DIN = 8'h96;
    tick();
    Go = 1'b0;
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("rst_hi_q", {24'h0, Q}, 32'h0);
    chk("rst_hi_ovf", {31'h0, Ovf}, 32'h0);
    chk("rst_hi_busy", {31'h0, Busy}, 32'h0);
    chk("rst_hi_done", {31'h0, Done}, 32'h0);
    tick(); tick(); tick();

    // Go held for 12 cycles
    sb_q.push_back({1'b0, 8'h01});
    sb_q.push_back({1'b0, 8'h02});
    sb_q.push_back({1'b0, 8'h03});
    ndone = 0;
    Go = 1'b1; DIN = 8'h01;
    repeat (12) begin
      tick();
      if (Done === 1'b1) ndone++;
    end
    Go = 1'b0;
    chk("hold_done_count", ndone, 32'd3);
    chk("hold_q", {24'h0, Q}, 32'h03);
    tick(); tick(); tick(); tick();
    chk("hold_idle", {31'h0, Busy}, 32'h0);

    chk("sb_empty", sb_q.size(), 32'd0);
    chk("err_q_empty", err_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
